// File: rtl/rng_state_reader.sv
// Snapshots the RNG full-state bus on start and streams a window of bytes out over valid/ready.
// Optional trailing CRC-8 beat when RNG_STATE_READER_CRC_EN is defined.
module rng_state_reader #(
    parameter int NUM_BYTES  = 32,
    parameter int TOTAL_BITS = 8 * NUM_BYTES,
    parameter int IDX_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TOTAL_BITS-1:0] state_in,
    input  logic                  start,
    input  logic [IDX_W-1:0]      rd_base,
    input  logic [IDX_W:0]        rd_len,
    output logic                  busy,
    output logic                  start_err,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [7:0]            m_data,
    output logic [IDX_W-1:0]      m_idx,
    output logic                  m_last,
    output logic                  done
);
    // state | meaning
    // IDLE  | waiting for start; validates window
    // SEND  | streaming snapshot bytes
    // CRC   | emitting trailing CRC-8 beat (CRC build only)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CRC  = 2'd2
    } state_t;

    localparam logic [IDX_W:0]   NB       = (IDX_W + 1)'(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_t                state_q, state_d;
    logic [TOTAL_BITS-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W:0]        rem_q, rem_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [7:0]            byte_sel;
    logic                  xfer;
    logic                  req_ok;

    always_comb begin
        byte_sel = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) byte_sel = snap_q[8*i +: 8];
        end
    end

    assign req_ok = (rd_len != '0) && (rd_len <= NB) && ({1'b0, rd_base} < NB);
    assign xfer   = m_valid && m_ready;

`ifdef RNG_STATE_READER_CRC_EN
    logic [7:0] crc_q, crc_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int b = 0; b < 8; b++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= 8'h00;
        else        crc_q <= crc_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef RNG_STATE_READER_CRC_EN
        crc_d   = crc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (req_ok) begin
                        snap_d  = state_in;
                        idx_d   = rd_base;
                        rem_d   = rd_len;
                        state_d = ST_SEND;
`ifdef RNG_STATE_READER_CRC_EN
                        crc_d   = 8'h00;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                    rem_d = rem_q - (IDX_W + 1)'(1);
`ifdef RNG_STATE_READER_CRC_EN
                    crc_d = crc8_step(crc_q, byte_sel);
                    if (rem_q == (IDX_W + 1)'(1)) state_d = ST_CRC;
`else
                    if (rem_q == (IDX_W + 1)'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
`ifdef RNG_STATE_READER_CRC_EN
            ST_CRC: begin
                if (xfer) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode straight from state so reset drops m_valid asynchronously.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        m_valid   = (state_q != ST_IDLE);
        m_data    = byte_sel;
        m_idx     = idx_q;
        done      = done_q;
        start_err = err_q;
`ifdef RNG_STATE_READER_CRC_EN
        m_last    = 1'b0;
        if (state_q == ST_CRC) begin
            m_data = crc_q;
            m_idx  = '0;
            m_last = 1'b1;
        end
`else
        m_last    = (state_q == ST_SEND) && (rem_q == (IDX_W + 1)'(1));
`endif
    end
endmodule

// File: tb/tb_rng_state_reader.sv
// Directed bench for rng_state_reader; CRC scenario runs when RNG_STATE_READER_CRC_EN is defined.
module tb_rng_state_reader;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] state_in = '0;
    logic         start = 1'b0;
    logic [4:0]   rd_base = '0;
    logic [5:0]   rd_len = '0;
    logic         busy, start_err, m_valid, m_ready, m_last, done;
    logic [7:0]   m_data;
    logic [4:0]   m_idx;

    int n_assert = 0;
    int n_fail   = 0;

    rng_state_reader dut (
        .clk(clk), .rst_n(rst_n), .state_in(state_in), .start(start),
        .rd_base(rd_base), .rd_len(rd_len), .busy(busy), .start_err(start_err),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
        .m_last(m_last), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic [4:0] i, input logic l);
        chk({tag, "_valid"}, 32'(m_valid), 32'd1);
        chk({tag, "_data"},  32'(m_data),  32'(d));
        chk({tag, "_idx"},   32'(m_idx),   32'(i));
        chk({tag, "_last"},  32'(m_last),  32'(l));
    endtask

    task automatic go(input logic [4:0] base, input logic [5:0] len);
        start = 1'b1; rd_base = base; rd_len = len;
        tick();
        start = 1'b0;
    endtask

    initial begin
        m_ready = 1'b0;
        // reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data",  32'(m_data),  32'h00);
        chk("rst_done",  32'(done),    32'd0);
        chk("rst_err",   32'(start_err), 32'd0);
        rst_n = 1'b1;
        tick();

`ifdef RNG_STATE_READER_CRC_EN
        state_in[7:0] = 8'h01;
        m_ready = 1'b1;
        go(5'd0, 6'd1);
        beat("crc_b0", 8'h01, 5'd0, 1'b0);
        tick();
        beat("crc_b1", 8'h07, 5'd0, 1'b1);
        chk("crc_nodone", 32'(done), 32'd0);
        tick();
        chk("crc_done",  32'(done),    32'd1);
        chk("crc_valid", 32'(m_valid), 32'd0);
        chk("crc_busy",  32'(busy),    32'd0);
        tick();
        chk("crc_done_pulse", 32'(done), 32'd0);
`else
        state_in[7:0] = 8'h0F; state_in[15:8] = 8'h55; state_in[23:16] = 8'hFF;
        state_in[255:248] = 8'hA5;

        // basic 3-byte read, no backpressure
        m_ready = 1'b1;
        go(5'd0, 6'd3);
        chk("t2_busy", 32'(busy), 32'd1);
        beat("t2_b0", 8'h0F, 5'd0, 1'b0);
        tick();
        beat("t2_b1", 8'h55, 5'd1, 1'b0);
        tick();
        beat("t2_b2", 8'hFF, 5'd2, 1'b1);
        chk("t2_nodone", 32'(done), 32'd0);
        tick();
        chk("t2_done",  32'(done),    32'd1);
        chk("t2_valid", 32'(m_valid), 32'd0);
        chk("t2_busy0", 32'(busy),    32'd0);
        tick();
        chk("t2_done1", 32'(done), 32'd0);

        // backpressure on beat 1, state_in overwrite and start while busy
        go(5'd0, 6'd3);
        beat("t3_b0", 8'h0F, 5'd0, 1'b0);
        state_in[15:8] = 8'h00;
        tick();
        m_ready = 1'b0;
        start = 1'b1; rd_base = 5'd2; rd_len = 6'd1;
        for (int k = 0; k < 4; k++) begin
            beat("t3_hold", 8'h55, 5'd1, 1'b0);
            tick();
            start = 1'b0;
            chk("t3_noerr", 32'(start_err), 32'd0);
        end
        beat("t3_hold_end", 8'h55, 5'd1, 1'b0);
        m_ready = 1'b1;
        tick();
        beat("t3_b2", 8'hFF, 5'd2, 1'b1);
        tick();
        chk("t3_done",  32'(done),    32'd1);
        chk("t3_valid", 32'(m_valid), 32'd0);
        tick();
        chk("t3_idle", 32'(m_valid), 32'd0);
        state_in[15:8] = 8'h55;

        // wrap from byte 31 to 0
        go(5'd31, 6'd3);
        beat("t4_b0", 8'hA5, 5'd31, 1'b0);
        tick();
        beat("t4_b1", 8'h0F, 5'd0, 1'b0);
        tick();
        beat("t4_b2", 8'h55, 5'd1, 1'b1);
        tick();
        chk("t4_done", 32'(done), 32'd1);

        // illegal lengths
        go(5'd0, 6'd0);
        chk("t5_err0",   32'(start_err), 32'd1);
        chk("t5_valid0", 32'(m_valid),   32'd0);
        chk("t5_busy0",  32'(busy),      32'd0);
        tick();
        chk("t5_err0_pulse", 32'(start_err), 32'd0);
        go(5'd0, 6'd33);
        chk("t5_err33",   32'(start_err), 32'd1);
        chk("t5_valid33", 32'(m_valid),   32'd0);
        tick();
        chk("t5_err33_pulse", 32'(start_err), 32'd0);
        chk("t5_idle", 32'(m_valid), 32'd0);

        // full 32-byte read starting mid-state
        for (int i = 0; i < 32; i++) state_in[8*i +: 8] = 8'(i) ^ 8'hC3;
        go(5'd5, 6'd32);
        for (int k = 0; k < 32; k++) begin
            beat("t6_full", 8'((k + 5) % 32) ^ 8'hC3, 5'((k + 5) % 32), (k == 31));
            tick();
        end
        chk("t6_done",  32'(done),    32'd1);
        chk("t6_valid", 32'(m_valid), 32'd0);

        // reset mid-stream
        go(5'd0, 6'd3);
        beat("t1_b0", 8'h3C ^ 8'h00 ^ 8'hFF, 5'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_async_valid", 32'(m_valid), 32'd0);
        chk("t1_async_busy",  32'(busy),    32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t1_nodone",  32'(done),    32'd0);
        chk("t1_valid",   32'(m_valid), 32'd0);
        tick();
        chk("t1_nodone2", 32'(done), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
